// File: rtl/video_stream_tx_pkg.sv
// rtl/video_stream_tx_pkg.sv - shared types and constants for video_stream_tx
// Purpose: raster FSM state encoding, pattern select codes, output pipeline depth
//          and the per-cycle control word carried down the output pipeline.
// Ports:   none (package).
package video_stream_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_V_PRE,
    S_LINE_ACT,
    S_LINE_BLK,
    S_V_POST
  } state_t;

  localparam logic [1:0] PAT_EXT   = 2'd0;
  localparam logic [1:0] PAT_HRAMP = 2'd1;
  localparam logic [1:0] PAT_VRAMP = 2'd2;
  localparam logic [1:0] PAT_CHK   = 2'd3;

  // Number of register stages between the FSM and the output pins.
  localparam int PIPE_DEPTH = 2;

  typedef struct packed {
    logic vvalid;
    logic hvalid;
    logic busy;
    logic frame_done;
  } ctl_t;

endpackage

// File: rtl/stream_tpg.sv
// rtl/stream_tpg.sv - combinational test pattern generator
// Purpose: pixel value for raster position (x, y) in the selected pattern.
// Ports:   x    in  XW  pixel column
//          y    in  YW  line number
//          sel  in  2   PAT_HRAMP / PAT_VRAMP / PAT_CHK (PAT_EXT gives 0)
//          pix  out DW  pattern pixel
module stream_tpg
  import video_stream_tx_pkg::*;
#(
  parameter int DW = 8,
  parameter int XW = 4,
  parameter int YW = 4
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    sel,
  output logic [DW-1:0] pix
);

  logic x4;
  logic y4;

  // Bit 4 via shift so narrow counters (fewer than 5 bits) read as 0.
  assign x4 = 1'(x >> 4);
  assign y4 = 1'(y >> 4);

  always_comb begin
    pix = '0;
    case (sel)
      PAT_HRAMP: pix = DW'(x);
      PAT_VRAMP: pix = DW'(y);
      PAT_CHK:   pix = (x4 ^ y4) ? '1 : '0;
      default:   pix = '0;
    endcase
  end

endmodule

// File: rtl/video_stream_tx.sv
// rtl/video_stream_tx.sv - raster vvalid/hvalid/data stream transmitter
// Purpose: generates frame/line timing and streams pixels from an external
//          synchronous source (pix_req -> pix_din one cycle later) or, when
//          built with STREAM_TPG_EN, from an internal test pattern.
// Ports:   clk          in  1   pixel clock
//          rst_b        in  1   asynchronous active-low reset
//          enable       in  1   frames run while high
//          pattern_sel  in  2   0 ext, 1 h-ramp, 2 v-ramp, 3 checker
//          pix_req      out 1   read strobe to pixel source
//          pix_din      in  DW  pixel from source, cycle after pix_req
//          vvalid       out 1   frame valid
//          hvalid       out 1   pixel valid
//          dout         out DW  pixel data (holds while hvalid=0)
//          frame_done   out 1   pulse on first V_POST output cycle
//          busy         out 1   high from frame start to end of V_POST
// Macro:   STREAM_TPG_EN enables pattern_sel 1..3; otherwise source is always external.
module video_stream_tx
  import video_stream_tx_pkg::*;
#(
  parameter int DW      = 8,
  parameter int H_ACT   = 1920,
  parameter int V_ACT   = 1080,
  parameter int H_BLANK = 280,
  parameter int V_PRE   = 16,
  parameter int V_POST  = 29
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          enable,
  input  logic [1:0]    pattern_sel,
  output logic          pix_req,
  input  logic [DW-1:0] pix_din,
  output logic          vvalid,
  output logic          hvalid,
  output logic [DW-1:0] dout,
  output logic          frame_done,
  output logic          busy
);

  localparam int XW    = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW    = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int T_MAX = (V_PRE > H_BLANK) ? ((V_PRE > V_POST) ? V_PRE : V_POST)
                                           : ((H_BLANK > V_POST) ? H_BLANK : V_POST);
  localparam int TW    = $clog2(T_MAX);

  localparam logic [XW-1:0] X_LAST      = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(V_ACT - 1);
  localparam logic [TW-1:0] T_PRE_LAST  = TW'(V_PRE - 1);
  localparam logic [TW-1:0] T_BLK_LAST  = TW'(H_BLANK - 1);
  localparam logic [TW-1:0] T_POST_LAST = TW'(V_POST - 1);

  state_t        state, next_state;
  logic [TW-1:0] tcnt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          frame_start;
  logic          use_ext;
  ctl_t          ctl_now;
  ctl_t          pipe [PIPE_DEPTH];

  assign frame_start = (next_state == S_V_PRE) && (state != S_V_PRE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:     if (enable) next_state = S_V_PRE;
      S_V_PRE:    if (tcnt == T_PRE_LAST) next_state = S_LINE_ACT;
      S_LINE_ACT: if (x == X_LAST) next_state = S_LINE_BLK;
      S_LINE_BLK: if (tcnt == T_BLK_LAST) next_state = (y == Y_LAST) ? S_V_POST : S_LINE_ACT;
      S_V_POST:   if (tcnt == T_POST_LAST) next_state = enable ? S_V_PRE : S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // tcnt times the fixed-length states and restarts on every state change,
  // so it never runs past its last value.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tcnt <= '0;
      x    <= '0;
      y    <= '0;
    end else begin
      if (next_state != state || state == S_IDLE || state == S_LINE_ACT) tcnt <= '0;
      else                                                               tcnt <= tcnt + 1'b1;

      if (frame_start) begin
        x <= '0;
        y <= '0;
      end else begin
        if (state == S_LINE_ACT) x <= (x == X_LAST) ? '0 : x + 1'b1;
        if (state == S_LINE_BLK && tcnt == T_BLK_LAST) y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end
    end
  end

`ifdef STREAM_TPG_EN
  logic [1:0]    sel_q;
  logic [DW-1:0] pat_pix;
  logic [DW-1:0] pat_q;

  // Pattern choice is frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)           sel_q <= PAT_EXT;
    else if (frame_start) sel_q <= pattern_sel;
  end

  stream_tpg #(.DW(DW), .XW(XW), .YW(YW)) u_tpg (
    .x   (x),
    .y   (y),
    .sel (sel_q),
    .pix (pat_pix)
  );

  // First pipeline stage for pattern pixels, matching the source read latency.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) pat_q <= '0;
    else        pat_q <= pat_pix;
  end

  assign use_ext = (sel_q == PAT_EXT);
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^pattern_sel;
  assign use_ext = 1'b1;
`endif

  always_comb begin
    ctl_now            = '0;
    ctl_now.vvalid     = (state == S_V_PRE) || (state == S_LINE_ACT) || (state == S_LINE_BLK);
    ctl_now.hvalid     = (state == S_LINE_ACT);
    ctl_now.busy       = (state != S_IDLE);
    ctl_now.frame_done = (state == S_V_POST) && (tcnt == '0);
  end

  // pix_req is decoded from next_state so the registered strobe lines up with
  // the FSM state, PIPE_DEPTH cycles ahead of the matching hvalid.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pix_req <= 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else begin
      pix_req <= (next_state == S_LINE_ACT) && use_ext;
      pipe[0] <= ctl_now;
      for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dout <= '0;
    end else if (pipe[PIPE_DEPTH-2].hvalid) begin
`ifdef STREAM_TPG_EN
      dout <= use_ext ? pix_din : pat_q;
`else
      dout <= pix_din;
`endif
    end
  end

  assign vvalid     = pipe[PIPE_DEPTH-1].vvalid;
  assign hvalid     = pipe[PIPE_DEPTH-1].hvalid;
  assign busy       = pipe[PIPE_DEPTH-1].busy;
  assign frame_done = pipe[PIPE_DEPTH-1].frame_done;

endmodule
